// File: rtl/serial_pattern_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_transmitter_pkg
//   Definitions shared by the serial pattern transmitter and its golden
//   sequence-detector model:
//     PATTERN / PAT_LEN : the overlapping sequence the detector looks for.
//     HIST_W            : bits of X history needed alongside the current X.
//     tx_state_t        : transmitter FSM state encodings (IDLE/SHIFT/GAP).
// -----------------------------------------------------------------------------
package serial_pattern_transmitter_pkg;

  localparam int                 PAT_LEN = 6;
  localparam logic [PAT_LEN-1:0] PATTERN = 6'b101101;
  localparam int                 HIST_W  = PAT_LEN - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_t;

endpackage : serial_pattern_transmitter_pkg

// File: rtl/serial_pattern_transmitter_golden_model.sv
// -----------------------------------------------------------------------------
// seq_golden_model
//   Reference model of the overlapping 101101 sequence detector. Samples x on
//   every clock into a 5-bit history, flags expect_z combinationally when the
//   history plus the current x complete the pattern (Mealy-equivalent), and
//   keeps a saturating count of those flags. Usable standalone next to a
//   detector under test.
//
// Parameters
//   CNT_W       width of the match counter
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   clear       in   1      synchronous clear of history and counter
//   x           in   1      serial bit being observed
//   expect_z    out  1      current x completes the pattern
//   expect_cnt  out  CNT_W  saturating count of expect_z pulses
// -----------------------------------------------------------------------------
module seq_golden_model
  import serial_pattern_transmitter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             x,
  output logic             expect_z,
  output logic [CNT_W-1:0] expect_cnt
);

  logic [HIST_W-1:0] hist;

  // Hold at all-ones instead of wrapping so an overflowed count stays
  // recognisable as "at least this many".
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign expect_z = ({hist, x} == PATTERN);

  // History shifts every clock, idle zeros included, so matches may overlap
  // and may span word boundaries exactly as the detector sees them.
  // Clear wins over a simultaneous match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist       <= '0;
      expect_cnt <= '0;
    end else if (clear) begin
      hist       <= '0;
      expect_cnt <= '0;
    end else begin
      hist <= {hist[HIST_W-2:0], x};
      if (expect_z) begin
        expect_cnt <= sat_inc(expect_cnt);
      end
    end
  end

endmodule : seq_golden_model

// File: rtl/serial_pattern_transmitter.sv
// -----------------------------------------------------------------------------
// serial_pattern_transmitter
//   Accepts WIDTH-bit words over a valid/ready handshake and serializes them
//   MSB-first onto X, one bit per clock, starting the cycle after the
//   accepting handshake. A golden model of the 101101 overlapping detector
//   watches X so the real detector's Z and match count can be checked on chip.
//
//   Default build: the last bit of a word may be followed immediately by the
//   first bit of the next word (load_ready is high during the last bit).
//   With SEQ_TX_GAP_EN defined: every word is followed by GAP_CYCLES idle
//   cycles (X=0, x_valid=0, load_ready=0) so matches cannot cross words.
//
// Parameters
//   WIDTH       bits per word (>= 2)
//   CNT_W       width of expect_cnt
//   GAP_CYCLES  idle cycles after each word (SEQ_TX_GAP_EN builds only)
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-low reset
//   clear       in   1      synchronous clear of expect_cnt and history
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      a word can be accepted this cycle
//   load_data   in   WIDTH  word to send, bit WIDTH-1 first
//   X           out  1      serial bit to the detector (0 when not shifting)
//   x_valid     out  1      X carries a data bit
//   busy        out  1      FSM not idle
//   frame_done  out  1      last bit of the word is on X this cycle
//   expect_z    out  1      X completes 101101 this cycle
//   expect_cnt  out  CNT_W  saturating match count
// -----------------------------------------------------------------------------
module serial_pattern_transmitter
  import serial_pattern_transmitter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             expect_z,
  output logic [CNT_W-1:0] expect_cnt
);

  localparam int             BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [BC_W-1:0]  bit_cnt;
  logic             last_bit;
  logic             accept;

`ifdef SEQ_TX_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt;
`endif

  // All status outputs are plain decodes of registered state, so reset
  // forces them to their idle values immediately.
  assign last_bit   = (state == ST_SHIFT) && (bit_cnt == '0);
  assign x_valid    = (state == ST_SHIFT);
  assign X          = x_valid & shreg[WIDTH-1];
  assign busy       = (state != ST_IDLE);
  assign frame_done = last_bit;

`ifdef SEQ_TX_GAP_EN
  assign load_ready = (state == ST_IDLE);
`else
  // Ready during the last bit gives zero-bubble back-to-back words.
  assign load_ready = (state == ST_IDLE) || last_bit;
`endif

  assign accept = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef SEQ_TX_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= load_data;
            bit_cnt <= LAST_BIT;
            state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt != '0) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            shreg <= '0;
`ifdef SEQ_TX_GAP_EN
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
`else
            if (accept) begin
              shreg   <= load_data;
              bit_cnt <= LAST_BIT;
            end else begin
              state <= ST_IDLE;
            end
`endif
          end
        end

`ifdef SEQ_TX_GAP_EN
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

  seq_golden_model #(
    .CNT_W (CNT_W)
  ) u_golden (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .x          (X),
    .expect_z   (expect_z),
    .expect_cnt (expect_cnt)
  );

endmodule : serial_pattern_transmitter
